// File: rtl/byte_word_packer.sv
// Purpose: packs a valid/ready byte stream into upper-lane-first words, flushing partial words on last.
// Latency: a word appears on out_* one cycle after its completing byte is accepted.
// Backpressure: in_ready = !out_valid || out_ready; no byte is taken while a held word is stalled.
module byte_word_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [7:0]                  in_byte,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [8*BYTES_PER_WORD-1:0] out_word,
   output logic [BYTES_PER_WORD-1:0]   out_keep,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CNT_WIDTH-1:0]        word_count
);

   localparam int W  = 8 * BYTES_PER_WORD;
   localparam int IW = $clog2(BYTES_PER_WORD);

   // Output register occupancy: EMPTY accepts freely, FULL only when the sink drains it.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                    state;
   logic [W-1:0]              acc;
   logic [BYTES_PER_WORD-1:0] mask;
   logic [IW-1:0]             idx;

   logic [IW-1:0]             lane;
   logic [W-1:0]              merged_word;
   logic [BYTES_PER_WORD-1:0] merged_mask;
   logic                      accept;
   logic                      out_fire;
   logic                      complete;

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign lane      = IW'(BYTES_PER_WORD - 1) - idx;
   assign complete  = accept && (in_last || (idx == IW'(BYTES_PER_WORD - 1)));

   // Accumulator with the incoming byte dropped into its lane (first byte lands in the top lane).
   always_comb begin
      merged_word = acc;
      merged_mask = mask;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (IW'(i) == lane) begin
            merged_word[8*i +: 8] = in_byte;
            merged_mask[i]        = 1'b1;
         end
      end
   end

   // Accumulate bytes, move completed words into the output register, count output handshakes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= EMPTY;
         acc        <= '0;
         mask       <= '0;
         idx        <= '0;
         out_word   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         word_count <= '0;
      end else begin
         if (complete) begin
            // A completion in the same edge as a handshake replaces the old word with no bubble.
            out_word <= merged_word;
            out_keep <= merged_mask;
            out_last <= in_last;
            state    <= FULL;
            acc      <= '0;
            mask     <= '0;
            idx      <= '0;
         end else begin
            if (accept) begin
               acc  <= merged_word;
               mask <= merged_mask;
               idx  <= idx + IW'(1);
            end
            if (out_fire) begin
               state <= EMPTY;
            end
         end
         if (out_fire) begin
            word_count <= word_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_byte_word_packer.sv
// Purpose: scoreboard bench for byte_word_packer against a queue-based packet model.
// Latency: expected words are queued when their completing byte is accepted, popped on handshake.
// Backpressure: the model derives readiness from its own held-word state and random out_ready.
module tb_byte_word_packer;

   localparam int BPW = 4;
   localparam int W   = 8 * BPW;

   typedef struct packed {
      logic [W-1:0]   word;
      logic [BPW-1:0] keep;
      logic           last;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [7:0]     in_byte = 8'h00;
   logic           in_valid = 1'b0;
   logic           in_last = 1'b0;
   logic           in_ready;
   logic [W-1:0]   out_word;
   logic [BPW-1:0] out_keep;
   logic           out_last;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [15:0]    word_count;

   logic           in_ready4;
   logic [W-1:0]   out_word4;
   logic [BPW-1:0] out_keep4;
   logic           out_last4;
   logic           out_valid4;
   logic [3:0]     word_count4;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   exp_t        exp_q[$];
   logic [7:0]  cur[$];
   bit          held = 0;
   int          cnt = 0;

   byte_word_packer #(.BYTES_PER_WORD(BPW), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_word(out_word), .out_keep(out_keep), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count)
   );

   // Same stream into a narrow-counter instance to observe wrap-around.
   byte_word_packer #(.BYTES_PER_WORD(BPW), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready4), .out_word(out_word4), .out_keep(out_keep4), .out_last(out_last4),
      .out_valid(out_valid4), .out_ready(out_ready), .word_count(word_count4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model is updated from the bench's own view of readiness.
   task automatic cycle(input logic v, input logic [7:0] b, input logic l, input logic r,
                        output bit acc);
      in_valid = v;
      in_byte  = b;
      in_last  = l;
      out_ready = r;
      @(negedge clk);
      acc = 0;
      if (!reset_n) begin
         exp_q.delete();
         cur.delete();
         held = 0;
         cnt  = 0;
      end else begin
         bit   rdy;
         exp_t e;
         rdy = !held || r;
         check("in_ready", 64'(in_ready), 64'(rdy));
         check("word_count", 64'(word_count), 64'(16'(cnt)));
         acc = v && rdy;
         if (held && r) begin
            held = 0;
            cnt++;
         end
         if (acc) begin
            cur.push_back(b);
            if (l || cur.size() == BPW) begin
               e = '0;
               for (int k = 0; k < cur.size(); k++) begin
                  e.word[(BPW-1-k)*8 +: 8] = cur[k];
                  e.keep[BPW-1-k]          = 1'b1;
               end
               e.last = l;
               exp_q.push_back(e);
               cur.delete();
               held = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l, input logic r);
      bit acc;
      int tries;
      acc = 0;
      tries = 0;
      while (!acc && tries < 20) begin
         cycle(1'b1, b, l, r, acc);
         tries++;
      end
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, tries);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
   endtask

   // Monitor: compares any presented word against the scoreboard head, pops on handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got %0h with nothing expected", out_word);
            end else begin
               check("out_word", 64'(out_word), 64'(exp_q[0].word));
               check("out_keep", 64'(out_keep), 64'(exp_q[0].keep));
               check("out_last", 64'(out_last), 64'(exp_q[0].last));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      // Reset with valid input present: it must be ignored.
      reset_n = 1'b0;
      cycle(1'b1, 8'hEE, 1'b1, 1'b1, acc);
      cycle(1'b1, 8'hEF, 1'b0, 1'b1, acc);
      reset_n = 1'b1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_word", 64'(out_word), 64'(0));
      check("rst_out_keep", 64'(out_keep), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_word_count", 64'(word_count), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Full word, back-to-back.
      send_byte(8'h11, 1'b0, 1'b1);
      send_byte(8'h22, 1'b0, 1'b1);
      send_byte(8'h33, 1'b0, 1'b1);
      send_byte(8'h44, 1'b0, 1'b1);
      idle(2);

      // Partial flush, then next word starts at the top lane.
      send_byte(8'hAA, 1'b0, 1'b1);
      send_byte(8'hBB, 1'b1, 1'b1);
      send_byte(8'hCC, 1'b0, 1'b1);
      send_byte(8'hDD, 1'b1, 1'b1);
      idle(2);

      // Single-byte packet.
      send_byte(8'h5A, 1'b1, 1'b1);
      idle(2);

      // Backpressure with the stream held valid.
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h05, 1'b0, 1'b0, acc);
      for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b1);
      idle(2);

      // Reset mid-word discards the partial accumulator.
      send_byte(8'h10, 1'b0, 1'b1);
      send_byte(8'h20, 1'b0, 1'b1);
      reset_n = 1'b0;
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
      reset_n = 1'b1;
      send_byte(8'h30, 1'b0, 1'b1);
      send_byte(8'h40, 1'b0, 1'b1);
      send_byte(8'h50, 1'b0, 1'b1);
      send_byte(8'h60, 1'b0, 1'b1);
      idle(2);
      check("count_after_reset", 64'(word_count), 64'(1));

      // Random traffic with random backpressure and packet ends.
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 2) != 0), acc);
      end
      idle(4);

      check("drained", 64'(exp_q.size()), 64'(0));
      check("final_count", 64'(word_count), 64'(16'(cnt)));
      check("wrap_count", 64'(word_count4), 64'(4'(cnt)));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
